// File: rtl/product_bcd_converter_pkg.sv
// Shared constants and types for the multiplier result path and its BCD converter.
package mult_pkg;

  localparam int PROD_W     = 16;
  localparam int BCD_DIGITS = 5;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Capture/result bundle between the multiplier side (master) and the BCD converter (slave).
interface product_bcd_converter_if #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int DIGITS = mult_pkg::BCD_DIGITS
);

  logic [PROD_W-1:0]   product8x8;
  logic                doneflag;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output product8x8,
    output doneflag,
    input  bcd_out,
    input  bcd_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  product8x8,
    input  doneflag,
    output bcd_out,
    output bcd_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/product_bcd_converter_digit_adjust.sv
// One double-dabble digit corrector: adds 3 to a nibble of 5 or more so the next shift carries decimally.
module bcd_digit_adjust (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  import mult_pkg::*;

  // Nibble-local add-3 correction, no carry out of the digit
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= BCD_ADJ_THRESH) begin
      o_nib = i_nib + 4'd3;
    end else begin
      o_nib = i_nib;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Captures a product on the rising edge of doneflag and converts it to packed BCD,
// one double-dabble iteration per clock; the last result is held for the readout stage.
module product_bcd_converter #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int DIGITS = mult_pkg::BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    reseta,
  product_bcd_converter_if.slave  bus
);

  import mult_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CAT_W = BCD_W + PROD_W;
  localparam int CNT_W = (PROD_W > 1) ? $clog2(PROD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROD_W - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_done_q;
  logic [PROD_W-1:0]  r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_valid;
  logic               r_busy;
  logic               r_overrun;

  logic               w_req;
  logic               w_last;
  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic               w_drop;
  logic [BCD_W-1:0]   w_adj;
  logic [CAT_W-1:0]   w_cat;
  logic [CAT_W-1:0]   w_shifted;

  assign w_req  = bus.doneflag & ~r_done_q;
  assign w_last = (r_count == LAST_CNT);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_nib (r_acc[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // Whole {BCD, binary} word moves left together after the per-digit correction
  assign w_cat     = {w_adj, r_bin};
  assign w_shifted = w_cat << 1;

  // Edge detector history; clears on reset so a level held through release still requests once
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= bus.doneflag;
    end
  end

  // State register with busy registered alongside it
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == CONV);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = CONV;
        end else begin
          w_next = IDLE;
        end
      end
      CONV: begin
        if (w_last) begin
          w_next = IDLE;
        end else begin
          w_next = CONV;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Control decode per state
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_req;
      end
      CONV: begin
        w_step   = 1'b1;
        w_finish = w_last;
        w_drop   = w_req;
      end
      default: begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_drop   = 1'b0;
      end
    endcase
  end

  // Conversion datapath: load on capture, shift once per CONV cycle
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      r_bin   <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_bin   <= bus.product8x8;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_step) begin
      r_bin   <= w_shifted[PROD_W-1:0];
      r_acc   <= w_shifted[CAT_W-1:PROD_W];
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_bin   <= r_bin;
      r_acc   <= r_acc;
      r_count <= r_count;
    end
  end

  // Published result: changes only on completion, valid drops on the next accepted capture
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      r_bcd_out <= '0;
      r_valid   <= 1'b0;
    end else if (w_load) begin
      r_bcd_out <= r_bcd_out;
      r_valid   <= 1'b0;
    end else if (w_finish) begin
      r_bcd_out <= w_shifted[CAT_W-1:PROD_W];
      r_valid   <= 1'b1;
    end else begin
      r_bcd_out <= r_bcd_out;
      r_valid   <= r_valid;
    end
  end

  // Sticky record of requests dropped while converting
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign bus.bcd_out   = r_bcd_out;
  assign bus.bcd_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and randomized bench for product_bcd_converter against a decimal-arithmetic reference.
module tb_product_bcd_converter;

  logic clk;
  logic reseta;
  int   n_cmp;
  int   n_err;
  logic [19:0] exp_out;
  logic        exp_ovr;

  product_bcd_converter_if #(.PROD_W(16), .DIGITS(5)) ifc ();

  product_bcd_converter #(.PROD_W(16), .DIGITS(5)) dut (
    .clk    (clk),
    .reseta (reseta),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0]  r;
    int unsigned  d;
    d = v;
    r = 20'd0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One conversion of p starting at the current negedge; optional second request raised
  // after edge E<late> (request seen at E<late+1>) carrying p2, which must be dropped.
  task automatic conv(input logic [15:0] p, input bit pulse, input int late,
                      input logic [15:0] p2, input bit fresh);
    logic [19:0] prev;
    if (fresh && ifc.doneflag) begin
      ifc.doneflag = 1'b0;
      @(negedge clk);
    end
    prev = exp_out;
    ifc.product8x8 = p;
    ifc.doneflag   = 1'b1;
    @(negedge clk);
    chk("busy_after_capture", 32'(ifc.busy), 32'd1);
    chk("valid_after_capture", 32'(ifc.bcd_valid), 32'd0);
    chk("out_held_at_capture", 32'(ifc.bcd_out), 32'(prev));
    if (pulse) ifc.doneflag = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (late > 0 && e == late + 1) begin
        ifc.doneflag   = 1'b1;
        ifc.product8x8 = p2;
      end
      if (late > 0 && e == late + 2) ifc.doneflag = 1'b0;
      @(negedge clk);
      if (e < 16) begin
        chk("busy_mid", 32'(ifc.busy), 32'd1);
        chk("valid_mid", 32'(ifc.bcd_valid), 32'd0);
        chk("out_held_mid", 32'(ifc.bcd_out), 32'(prev));
      end
    end
    if (late > 0 && late + 1 <= 16) exp_ovr = 1'b1;
    exp_out = to_bcd(32'(p));
    chk("result", 32'(ifc.bcd_out), 32'(exp_out));
    chk("valid_done", 32'(ifc.bcd_valid), 32'd1);
    chk("busy_done", 32'(ifc.busy), 32'd0);
    chk("overrun", 32'(ifc.overrun), 32'(exp_ovr));
  endtask

  initial begin
    logic [15:0] pa;
    logic [15:0] pb;
    int          busy_seen;
    n_cmp = 0;
    n_err = 0;
    exp_out = 20'd0;
    exp_ovr = 1'b0;
    reseta = 1'b1;
    ifc.product8x8 = 16'd0;
    ifc.doneflag   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reseta = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(ifc.bcd_out), 32'd0);
    chk("rst_valid", 32'(ifc.bcd_valid), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_overrun", 32'(ifc.overrun), 32'd0);

    // Maximum product
    conv(16'hFE01, 1'b1, 0, 16'd0, 1'b1);
    chk("max_literal", 32'(ifc.bcd_out), 32'h65025);

    // Zero then 12x10, back to back (second request lands on E17)
    conv(16'h0000, 1'b1, 0, 16'd0, 1'b1);
    conv(16'h0078, 1'b1, 0, 16'd0, 1'b1);
    chk("x78_literal", 32'(ifc.bcd_out), 32'h00120);

    // doneflag held high: exactly one conversion
    conv(16'h0051, 1'b0, 0, 16'd0, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (ifc.busy) busy_seen++;
    end
    chk("held_no_second_busy", 32'(busy_seen), 32'd0);
    chk("held_result", 32'(ifc.bcd_out), 32'h00081);
    ifc.doneflag = 1'b0;
    @(negedge clk);

    // Second request 5 cycles in is dropped; overrun survives a later good run
    pa = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
    conv(pa, 1'b1, 4, 16'h1234, 1'b1);
    pb = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
    conv(pb, 1'b1, 0, 16'd0, 1'b1);
    chk("overrun_sticky", 32'(ifc.overrun), 32'd1);

    // Reset at iteration 8, doneflag still high at release
    ifc.product8x8 = 16'hFE01;
    ifc.doneflag   = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    reseta = 1'b1;
    #1;
    chk("abort_out", 32'(ifc.bcd_out), 32'd0);
    chk("abort_valid", 32'(ifc.bcd_valid), 32'd0);
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_overrun", 32'(ifc.overrun), 32'd0);
    exp_out = 20'd0;
    exp_ovr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reseta = 1'b0;
    conv(16'hFE01, 1'b1, 0, 16'd0, 1'b0);

    // Request on the completion edge is dropped
    pa = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
    conv(pa, 1'b1, 15, 16'hBEEF, 1'b1);
    chk("completion_edge_overrun", 32'(ifc.overrun), 32'd1);

    // Randomized back-to-back runs, some with a dropped request mid-conversion
    for (int i = 0; i < 8; i++) begin
      pa = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      pb = 16'($urandom);
      if (i % 2 == 1) begin
        conv(pa, 1'b1, int'($urandom_range(1, 15)), pb, 1'b1);
      end else begin
        conv(pa, 1'b1, 0, 16'd0, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
